acc_host_link: RTL and testbench

- Accelerator-side responder to the UART host controller's toggle handshake.
- Detects `isNewDin`/`isNewWtin` toggles and captures the wide `din`/`wtin` words.
- Queues input vectors in an M-deep FIFO toward the datapath and holds the current weight block.
- Stores datapath results in an M-entry result buffer that the host reads through `addrDout`/`dout`.

---
 rtl/acc_host_link_if.sv | 43 ++++
 rtl/acc_host_link.sv | 111 +++++++++++
 tb/tb_acc_host_link.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/acc_host_link_if.sv
// Host/datapath bundle for acc_host_link.
// Master drives host and datapath inputs; slave is the link.
interface acc_host_link_if #(
  parameter int M      = 16,
  parameter int DIN_W  = 256,
  parameter int WT_W   = 1024,
  parameter int DOUT_W = 188
);
  localparam int AW = $clog2(M);
  localparam int CW = AW + 1;

  logic              isNewDin;
  logic              isNewWtin;
  logic [DIN_W-1:0]  din;
  logic [WT_W-1:0]   wtin;
  logic [AW-1:0]     addrDout;
  logic [DOUT_W-1:0] dout;
  logic [DIN_W-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WT_W-1:0]   wt_data;
  logic              wt_load;
  logic              res_valid;
  logic [DOUT_W-1:0] res_data;
  logic              clr;
  logic [CW-1:0]     in_count;
  logic [CW-1:0]     res_count;
  logic              in_overflow;

  modport master (
    output isNewDin, isNewWtin, din, wtin, addrDout,
    output in_ready, res_valid, res_data, clr,
    input  dout, in_data, in_valid, wt_data, wt_load,
    input  in_count, res_count, in_overflow
  );

  modport slave (
    input  isNewDin, isNewWtin, din, wtin, addrDout,
    input  in_ready, res_valid, res_data, clr,
    output dout, in_data, in_valid, wt_data, wt_load,
    output in_count, res_count, in_overflow
  );
endinterface

// File: rtl/acc_host_link.sv
// Accelerator-side responder to the host toggle handshake:
// input FIFO, weight latch and readable result buffer.
module acc_host_link #(
  parameter int M      = 16,
  parameter int DIN_W  = 256,
  parameter int WT_W   = 1024,
  parameter int DOUT_W = 188
) (
  input logic            clock,
  input logic            reset,
  acc_host_link_if.slave bus
);
  localparam int AW = $clog2(M);
  localparam int CW = AW + 1;

  logic              din_prev;
  logic              wt_prev;
  logic              din_ev;
  logic              wt_ev;
  logic [DIN_W-1:0]  mem [M];
  logic [DOUT_W-1:0] resmem [M];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     res_wptr;
  logic [CW-1:0]     in_cnt;
  logic [CW-1:0]     res_cnt;
  logic              ovf;
  logic              full;
  logic              valid;
  logic              pop;
  logic              push;
  logic [WT_W-1:0]   wt_q;
  logic              wt_ld;
  logic [DOUT_W-1:0] dout_q;

  assign din_ev = bus.isNewDin != din_prev;
  assign wt_ev  = bus.isNewWtin != wt_prev;
  assign full   = in_cnt == CW'(M);
  assign valid  = in_cnt != '0;
  assign pop    = valid && bus.in_ready;
  // a full FIFO still takes a word if the head leaves this cycle
  assign push   = din_ev && (!full || pop);

  assign bus.in_data     = mem[rptr];
  assign bus.in_valid    = valid;
  assign bus.in_count    = in_cnt;
  assign bus.in_overflow = ovf;
  assign bus.wt_data     = wt_q;
  assign bus.wt_load     = wt_ld;
  assign bus.res_count   = res_cnt;
  assign bus.dout        = dout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      din_prev <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      in_cnt   <= '0;
      ovf      <= 1'b0;
      for (int i = 0; i < M; i++) mem[i] <= '0;
    end else begin
      din_prev <= bus.isNewDin;
      if (bus.clr) begin
        wptr   <= '0;
        rptr   <= '0;
        in_cnt <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push) begin
          mem[wptr] <= bus.din;
          wptr      <= wptr + AW'(1);
        end
        if (pop) rptr <= rptr + AW'(1);
        if (push && !pop) in_cnt <= in_cnt + CW'(1);
        else if (pop && !push) in_cnt <= in_cnt - CW'(1);
        if (din_ev && !push) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wt_prev <= 1'b0;
      wt_q    <= '0;
      wt_ld   <= 1'b0;
    end else begin
      wt_prev <= bus.isNewWtin;
      wt_ld   <= wt_ev;
      if (wt_ev) wt_q <= bus.wtin;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_wptr <= '0;
      res_cnt  <= '0;
      dout_q   <= '0;
      for (int i = 0; i < M; i++) resmem[i] <= '0;
    end else begin
      dout_q <= resmem[bus.addrDout];
      if (bus.clr) begin
        res_wptr <= '0;
        res_cnt  <= '0;
      end else if (bus.res_valid) begin
        resmem[res_wptr] <= bus.res_data;
        res_wptr         <= res_wptr + AW'(1);
        if (res_cnt != CW'(M)) res_cnt <= res_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_acc_host_link.sv
// Directed bench for acc_host_link with a queue
// scoreboard for the input FIFO and a model of the result buffer.
module tb_acc_host_link;
  localparam int M      = 16;
  localparam int DIN_W  = 256;
  localparam int WT_W   = 1024;
  localparam int DOUT_W = 188;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [DIN_W-1:0]  fifo_q [$];
  logic [DOUT_W-1:0] res_exp [M];
  logic [DIN_W-1:0]  xw;
  logic [WT_W-1:0]   wa;
  logic [WT_W-1:0]   wb;
  logic [DOUT_W-1:0] old5;

  acc_host_link_if #(
    .M(M), .DIN_W(DIN_W), .WT_W(WT_W), .DOUT_W(DOUT_W)
  ) bus ();

  acc_host_link #(
    .M(M), .DIN_W(DIN_W), .WT_W(WT_W), .DOUT_W(DOUT_W)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [255:0] obs,
                     logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wt(string tag, logic [WT_W-1:0] obs,
                        logic [WT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed_lo=%0h expected_lo=%0h",
             tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DIN_W-1:0] dw(int k);
    return {16{16'(k)}};
  endfunction

  function automatic logic [DOUT_W-1:0] rw(int k);
    return DOUT_W'(k + 1) | (DOUT_W'(k * 7 + 3) << 120);
  endfunction

  task automatic push(logic [DIN_W-1:0] w, bit store);
    bus.din      = w;
    bus.isNewDin = ~bus.isNewDin;
    if (store) fifo_q.push_back(w);
    step();
  endtask

  task automatic pop1(string tag);
    logic [DIN_W-1:0] e;
    if (fifo_q.size() == 0) e = '0;
    else e = fifo_q.pop_front();
    chk(tag, bus.in_valid, 1);
    chk(tag, bus.in_data, e);
    bus.in_ready = 1'b1;
    step();
    bus.in_ready = 1'b0;
  endtask

  task automatic wres(int k, int idx);
    bus.res_valid = 1'b1;
    bus.res_data  = rw(k);
    res_exp[idx]  = rw(k);
    step();
    bus.res_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.isNewDin = 1'b0;
    bus.isNewWtin = 1'b0;
    bus.din = '0;
    bus.wtin = '0;
    bus.addrDout = '0;
    bus.in_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    bus.clr = 1'b0;
    wa = {256{4'hA}};
    wb = {256{4'h3}};
    for (int i = 0; i < M; i++) res_exp[i] = '0;
    repeat (2) step();
    chk("rst_in_valid", bus.in_valid, 0);
    chk("rst_in_count", bus.in_count, 0);
    chk("rst_res_count", bus.res_count, 0);
    chk("rst_wt_load", bus.wt_load, 0);
    chk("rst_ovf", bus.in_overflow, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_in_data", bus.in_data, 0);
    chk_wt("rst_wt_data", bus.wt_data, '0);
    rst_n = 1'b1;
    step();

    push({32{8'h01}}, 1'b1);
    chk("first_count", bus.in_count, 1);
    pop1("first_pop");
    chk("first_empty", bus.in_valid, 0);
    chk("first_count0", bus.in_count, 0);

    for (int k = 1; k <= 17; k++) push(dw(k), k <= 16);
    chk("full_count", bus.in_count, 16);
    chk("full_ovf", bus.in_overflow, 1);
    for (int k = 1; k <= 16; k++) pop1("drain");
    chk("drain_empty", bus.in_valid, 0);
    chk("drain_count", bus.in_count, 0);
    chk("ovf_sticky", bus.in_overflow, 1);

    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk("clr_ovf", bus.in_overflow, 0);
    for (int k = 0; k < 16; k++) push(dw(16'h100 + k), 1'b1);
    chk("refill_count", bus.in_count, 16);
    xw = {8{32'hCAFE_F00D}};
    bus.din = xw;
    bus.isNewDin = ~bus.isNewDin;
    chk("pp_head", bus.in_data, fifo_q.pop_front());
    fifo_q.push_back(xw);
    bus.in_ready = 1'b1;
    step();
    bus.in_ready = 1'b0;
    chk("pp_count", bus.in_count, 16);
    chk("pp_ovf", bus.in_overflow, 0);
    for (int k = 0; k < 16; k++) pop1("pp_drain");
    chk("pp_empty", bus.in_valid, 0);

    bus.wtin = wa;
    bus.isNewWtin = ~bus.isNewWtin;
    step();
    chk("wt_load_a", bus.wt_load, 1);
    chk_wt("wt_data_a", bus.wt_data, wa);
    bus.wtin = wb;
    bus.isNewWtin = ~bus.isNewWtin;
    step();
    chk("wt_load_b", bus.wt_load, 1);
    chk_wt("wt_data_b", bus.wt_data, wb);
    step();
    chk("wt_load_off", bus.wt_load, 0);
    chk_wt("wt_hold", bus.wt_data, wb);

    for (int k = 0; k < 18; k++) wres(k, k % M);
    chk("res_count_sat", bus.res_count, 16);
    bus.addrDout = 4'd0;
    step();
    chk("rd0_r16", bus.dout, rw(16));
    bus.addrDout = 4'd1;
    step();
    chk("rd1_r17", bus.dout, rw(17));
    bus.addrDout = 4'd2;
    step();
    chk("rd2_r2", bus.dout, rw(2));

    for (int k = 2; k < 5; k++) wres(100 + k, k);
    old5 = res_exp[5];
    bus.addrDout = 4'd5;
    wres(105, 5);
    chk("rw_old", bus.dout, old5);
    step();
    chk("rw_new", bus.dout, rw(105));
    bus.addrDout = 4'd3;
    step();
    chk("rd3", bus.dout, res_exp[3]);

    push(dw(7), 1'b0);
    chk("pre_clr_valid", bus.in_valid, 1);
    bus.clr = 1'b1;
    bus.din = dw(9);
    bus.isNewDin = ~bus.isNewDin;
    step();
    bus.clr = 1'b0;
    chk("clr_in_count", bus.in_count, 0);
    chk("clr_res_count", bus.res_count, 0);
    chk("clr_valid", bus.in_valid, 0);
    step();
    chk("clr_consumed", bus.in_valid, 0);
    chk_wt("clr_wt_kept", bus.wt_data, wb);
    bus.addrDout = 4'd5;
    step();
    chk("clr_mem_kept", bus.dout, rw(105));

    push(dw(3), 1'b0);
    chk("mid_valid", bus.in_count, 1);
    #2;
    rst_n = 1'b0;
    bus.isNewDin = 1'b0;
    bus.isNewWtin = 1'b0;
    #1;
    chk("arst_count", bus.in_count, 0);
    chk("arst_dout", bus.dout, 0);
    chk_wt("arst_wt", bus.wt_data, '0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", bus.in_valid, 0);
    chk("post_rst_wt_load", bus.wt_load, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
